birukee_rtl_vecop_dma: RTL and testbench
========================================

# birukee_rtl_vecop_dma

Parametrised ESP accelerator core that streams two input vectors from memory over the 64-bit DMA interface, combines them lane-wise (add, sub, mul, signed max) and writes the result vector back. It replaces the stub DMA64 wrapper as the next-generation accelerator tile. It is chunked by a configurable maximum burst and holds one chunk in an on-chip buffer. Data movement is strictly sequential (read A, read B, write) per chunk.

## Interface
- DMA_WIDTH, 64: DMA channel width in bits.
- ELEM_WIDTH, 32: lane width; LANES = DMA_WIDTH/ELEM_WIDTH; must divide evenly.
- MAX_BURST, 16: max beats per DMA transaction and buffer depth (power of 2, ≥2).
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- conf_info_len  in  32  vector length in DMA beats.
- conf_info_mode  in  32  bits[1:0]: 0 add, 1 sub (A−B), 2 mul (low ELEM_WIDTH bits), 3 signed max.
- conf_info_in1_base / conf_info_in2_base / conf_info_out_base  in  32 each  beat index of A, B, result.
- conf_done  in  1  start request, sampled only in IDLE.
- dma_read_ctrl_valid/ready  out/in  1  read request handshake.
- dma_read_ctrl_data_index / _length  out  32  beat index / beat count.
- dma_read_ctrl_data_size  out  3  constant 3'b011 (64-bit).
- dma_read_chnl_valid/ready  in/out  1; dma_read_chnl_data  in  DMA_WIDTH.
- dma_write_ctrl_valid/ready, _data_index, _data_length, _data_size: same as read, direction out/in.
- dma_write_chnl_valid/ready  out/in  1; dma_write_chnl_data  out  DMA_WIDTH.
- acc_done  out  1  one-cycle completion pulse.
- debug  out  32  {state[3:0], 12'b0, chunks_done[15:0]}.

## Operation
- FSM: IDLE → RD_A_REQ → RD_A_DATA → RD_B_REQ → RD_B_DATA → WR_REQ → WR_DATA → (RD_A_REQ | DONE) → IDLE.
- IDLE: conf_done=1 latches all conf_info_*, sets remaining=len, offset=0. If len=0, go to DONE directly; otherwise go to RD_A_REQ. conf_done outside IDLE is ignored.
- chunk = min(remaining, MAX_BURST), computed on entry to RD_A_REQ and held for the chunk.
- RD_x_REQ: read_ctrl_valid=1, index=base_x+offset, length=chunk. Leave the state on valid&&ready.
- RD_A_DATA: read_chnl_ready=1. Each accepted beat is stored to buf[ptr], ptr++. After chunk beats, go to RD_B_REQ.
- RD_B_DATA: read_chnl_ready=1. Each accepted beat produces buf[ptr] ← op(buf[ptr], beat) lane-wise. Lane i is bits [i*ELEM_WIDTH +: ELEM_WIDTH].
- Arithmetic: add/sub/mul wrap modulo 2^ELEM_WIDTH. Max compares as two's complement.
- WR_REQ: write_ctrl_valid=1, index=out_base+offset, length=chunk.
- WR_DATA: write_chnl_valid=1, data=buf[ptr]; ptr++ on valid&&ready. After the last beat: offset+=chunk, remaining−=chunk, chunks_done++. Go to RD_A_REQ if remaining>0, else DONE.
- DONE: acc_done=1 for exactly one cycle, then IDLE.

## Timing
- All outputs are registered or decoded from state. Reset values: every valid=0, read_chnl_ready=0, acc_done=0, index/length=0, write data=0, debug=0, state=IDLE. The buffer is not cleared.
- Ctrl valid rises the cycle the state is entered. While valid=1, index/length/data stay stable until ready. Valid never drops without a handshake.
- Read beats are accepted only on valid&&ready. Read data arriving outside a *_DATA state is not accepted (ready=0).
- Write data is valid the cycle WR_DATA is entered (buffer read is combinational or prefetched). Zero-bubble back-to-back beats when ready stays high.
- Minimum single-chunk latency, always-ready memory, conf_done to acc_done: 1 + (1+N) + (1+N) + (1+N) + 1 cycles.
- Reset asserted mid-operation: immediate return to IDLE with reset output values. In-flight DMA is abandoned. No acc_done.
- remaining and offset are 32-bit. A final partial chunk uses length = remaining.

## Test plan
- len=4, mode add, A beats 0x00000001_00000002 ×4, B 0x00000010_00000020 → 4 writes of 0x00000011_00000022 at out_base; acc_done pulses once.
- len=20, MAX_BURST=16 → read/write lengths 16 then 4, offsets 0 and 16; debug[15:0]=2 at done.
- mode mul, lanes 0xFFFFFFFF×0x00000002 → 0xFFFFFFFE; mode sub 0−1 → 0xFFFFFFFF; mode max 0x80000000 vs 0x00000001 → 0x00000001.
- len=0, conf_done pulse → no ctrl valid ever, acc_done pulse 1 cycle after start.
- Random ready/valid backpressure on all four channels, len=37 → results bit-identical to the no-stall run; ctrl fields stable while valid&&!ready.
- rst low during RD_B_DATA → outputs at reset values next edge; new conf_done after release completes the full job correctly.

Source files
------------

// File: rtl/birukee_rtl_vecop_dma.sv
// birukee_rtl_vecop_dma: chunked DMA accelerator combining two vectors lane-wise (add, sub, mul, signed max)
module birukee_rtl_vecop_dma #(
  parameter int DMA_WIDTH  = 64,
  parameter int ELEM_WIDTH = 32,
  parameter int MAX_BURST  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          conf_info_len,
  input  logic [31:0]          conf_info_mode,
  input  logic [31:0]          conf_info_in1_base,
  input  logic [31:0]          conf_info_in2_base,
  input  logic [31:0]          conf_info_out_base,
  input  logic                 conf_done,
  output logic                 dma_read_ctrl_valid,
  input  logic                 dma_read_ctrl_ready,
  output logic [31:0]          dma_read_ctrl_data_index,
  output logic [31:0]          dma_read_ctrl_data_length,
  output logic [2:0]           dma_read_ctrl_data_size,
  input  logic                 dma_read_chnl_valid,
  output logic                 dma_read_chnl_ready,
  input  logic [DMA_WIDTH-1:0] dma_read_chnl_data,
  output logic                 dma_write_ctrl_valid,
  input  logic                 dma_write_ctrl_ready,
  output logic [31:0]          dma_write_ctrl_data_index,
  output logic [31:0]          dma_write_ctrl_data_length,
  output logic [2:0]           dma_write_ctrl_data_size,
  output logic                 dma_write_chnl_valid,
  input  logic                 dma_write_chnl_ready,
  output logic [DMA_WIDTH-1:0] dma_write_chnl_data,
  output logic                 acc_done,
  output logic [31:0]          debug
);
  localparam int LANES = DMA_WIDTH / ELEM_WIDTH;
  localparam int PW    = $clog2(MAX_BURST);

  typedef enum logic [3:0] {IDLE, RD_A_REQ, RD_A_DATA, RD_B_REQ, RD_B_DATA, WR_REQ, WR_DATA, DONE} state_t;

  state_t               state_q, state_d;
  logic [1:0]           mode_q;
  logic [31:0]          in1_q, in2_q, out_q, remaining_q, offset_q, chunk;
  logic [15:0]          chunks_q;
  logic [PW-1:0]        ptr_q;
  logic [DMA_WIDTH-1:0] buf_q [MAX_BURST];
  logic [DMA_WIDTH-1:0] op_res;
  logic                 rd_hs, wr_hs, last, unused_mode;

  assign chunk       = remaining_q < 32'(MAX_BURST) ? remaining_q : 32'(MAX_BURST);
  assign last        = 32'(ptr_q) == chunk - 32'd1;
  assign rd_hs       = dma_read_chnl_valid & dma_read_chnl_ready;
  assign wr_hs       = dma_write_chnl_valid & dma_write_chnl_ready;
  assign unused_mode = ^conf_info_mode[31:2];

  function automatic logic [ELEM_WIDTH-1:0] lane_op(input logic [1:0] m, input logic [ELEM_WIDTH-1:0] a, b);
    return m == 2'd0 ? a + b : m == 2'd1 ? a - b : m == 2'd2 ? a * b : ($signed(a) > $signed(b) ? a : b);
  endfunction

  always_comb begin
    op_res = '0;
    for (int i = 0; i < LANES; i++)
      op_res[i*ELEM_WIDTH +: ELEM_WIDTH] = lane_op(mode_q, buf_q[ptr_q][i*ELEM_WIDTH +: ELEM_WIDTH],
                                                   dma_read_chnl_data[i*ELEM_WIDTH +: ELEM_WIDTH]);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (conf_done) state_d = conf_info_len == 32'd0 ? DONE : RD_A_REQ;
      RD_A_REQ:  if (dma_read_ctrl_ready) state_d = RD_A_DATA;
      RD_A_DATA: if (rd_hs && last) state_d = RD_B_REQ;
      RD_B_REQ:  if (dma_read_ctrl_ready) state_d = RD_B_DATA;
      RD_B_DATA: if (rd_hs && last) state_d = WR_REQ;
      WR_REQ:    if (dma_write_ctrl_ready) state_d = WR_DATA;
      WR_DATA:   if (wr_hs && last) state_d = remaining_q == chunk ? DONE : RD_A_REQ;
      default:   state_d = IDLE;
    endcase
  end

  assign dma_read_ctrl_valid        = state_q == RD_A_REQ || state_q == RD_B_REQ;
  assign dma_read_ctrl_data_index   = (state_q == RD_B_REQ ? in2_q : in1_q) + offset_q;
  assign dma_read_ctrl_data_length  = chunk;
  assign dma_read_ctrl_data_size    = 3'b011;
  assign dma_read_chnl_ready        = state_q == RD_A_DATA || state_q == RD_B_DATA;
  assign dma_write_ctrl_valid       = state_q == WR_REQ;
  assign dma_write_ctrl_data_index  = out_q + offset_q;
  assign dma_write_ctrl_data_length = chunk;
  assign dma_write_ctrl_data_size   = 3'b011;
  assign dma_write_chnl_valid       = state_q == WR_DATA;
  assign dma_write_chnl_data        = dma_write_chnl_valid ? buf_q[ptr_q] : '0;
  assign acc_done                   = state_q == DONE;
  assign debug                      = {state_q, 12'b0, chunks_q};

  always_ff @(posedge clk or negedge rst)
    if (!rst) state_q <= IDLE;
    else state_q <= state_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q      <= '0;
      in1_q       <= '0;
      in2_q       <= '0;
      out_q       <= '0;
      remaining_q <= '0;
      offset_q    <= '0;
      chunks_q    <= '0;
      ptr_q       <= '0;
    end else begin
      if (state_q == IDLE && conf_done) begin
        mode_q      <= conf_info_mode[1:0];
        in1_q       <= conf_info_in1_base;
        in2_q       <= conf_info_in2_base;
        out_q       <= conf_info_out_base;
        remaining_q <= conf_info_len;
        offset_q    <= '0;
        chunks_q    <= '0;
      end
      if (rd_hs || wr_hs) ptr_q <= last ? '0 : ptr_q + PW'(1);
      if (wr_hs && last) begin
        offset_q    <= offset_q + chunk;
        remaining_q <= remaining_q - chunk;
        chunks_q    <= chunks_q + 16'd1;
      end
    end
  end

  // Chunk buffer: A beats are stored, B beats overwrite each slot with the combined result
  always_ff @(posedge clk)
    if (rd_hs) buf_q[ptr_q] <= state_q == RD_A_DATA ? dma_read_chnl_data : op_res;
endmodule

// File: tb/tb_birukee_rtl_vecop_dma.sv
// tb_birukee_rtl_vecop_dma: randomized scoreboard bench with a memory responder and a lane-wise reference model
module tb_birukee_rtl_vecop_dma;
  logic        clk = 0, rst = 0;
  logic [31:0] conf_info_len = 0, conf_info_mode = 0, conf_info_in1_base = 0, conf_info_in2_base = 0, conf_info_out_base = 0;
  logic        conf_done = 0;
  logic        dma_read_ctrl_valid, dma_read_ctrl_ready = 0, dma_read_chnl_valid = 0, dma_read_chnl_ready;
  logic [31:0] dma_read_ctrl_data_index, dma_read_ctrl_data_length, dma_write_ctrl_data_index, dma_write_ctrl_data_length;
  logic [2:0]  dma_read_ctrl_data_size, dma_write_ctrl_data_size;
  logic [63:0] dma_read_chnl_data = 0, dma_write_chnl_data;
  logic        dma_write_ctrl_valid, dma_write_ctrl_ready = 0, dma_write_chnl_valid, dma_write_chnl_ready = 0;
  logic        acc_done;
  logic [31:0] debug;

  birukee_rtl_vecop_dma dut (
    .clk(clk), .rst(rst),
    .conf_info_len(conf_info_len), .conf_info_mode(conf_info_mode),
    .conf_info_in1_base(conf_info_in1_base), .conf_info_in2_base(conf_info_in2_base),
    .conf_info_out_base(conf_info_out_base), .conf_done(conf_done),
    .dma_read_ctrl_valid(dma_read_ctrl_valid), .dma_read_ctrl_ready(dma_read_ctrl_ready),
    .dma_read_ctrl_data_index(dma_read_ctrl_data_index), .dma_read_ctrl_data_length(dma_read_ctrl_data_length),
    .dma_read_ctrl_data_size(dma_read_ctrl_data_size),
    .dma_read_chnl_valid(dma_read_chnl_valid), .dma_read_chnl_ready(dma_read_chnl_ready),
    .dma_read_chnl_data(dma_read_chnl_data),
    .dma_write_ctrl_valid(dma_write_ctrl_valid), .dma_write_ctrl_ready(dma_write_ctrl_ready),
    .dma_write_ctrl_data_index(dma_write_ctrl_data_index), .dma_write_ctrl_data_length(dma_write_ctrl_data_length),
    .dma_write_ctrl_data_size(dma_write_ctrl_data_size),
    .dma_write_chnl_valid(dma_write_chnl_valid), .dma_write_chnl_ready(dma_write_chnl_ready),
    .dma_write_chnl_data(dma_write_chnl_data),
    .acc_done(acc_done), .debug(debug)
  );

  always #5 clk = ~clk;

  typedef struct {logic [31:0] idx; logic [31:0] len;} ctrl_t;
  typedef struct {logic [31:0] addr; logic [63:0] data;} beat_t;

  ctrl_t       exp_rd[$], exp_wr[$];
  beat_t       exp_bt[$];
  logic [63:0] mem [0:1023];
  int          checks = 0, failures = 0;
  int          cyc = 0, acc_cnt = 0, acc_cyc = 0, exp_chunks = 0;
  int          rd_addr = 0, rd_left = 0;
  bit          stall = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_op(input int m, input logic [63:0] a, input logic [63:0] b);
    logic [63:0] r;
    int x, y;
    for (int i = 0; i < 2; i++) begin
      x = a[i*32 +: 32];
      y = b[i*32 +: 32];
      case (m)
        0:       r[i*32 +: 32] = x + y;
        1:       r[i*32 +: 32] = x - y;
        2:       r[i*32 +: 32] = x * y;
        default: r[i*32 +: 32] = x > y ? x : y;
      endcase
    end
    return r;
  endfunction

  // Memory responder: drives readies/valids on the falling edge, tracks the accepted read burst
  initial begin
    forever begin
      @(negedge clk);
      dma_read_ctrl_ready  = !stall || ($urandom % 2) != 0;
      dma_write_ctrl_ready = !stall || ($urandom % 2) != 0;
      dma_write_chnl_ready = !stall || ($urandom % 3) != 0;
      dma_read_chnl_valid  = rd_left > 0 && (!stall || ($urandom % 3) != 0);
      dma_read_chnl_data   = dma_read_chnl_valid ? mem[rd_addr] : {$urandom, $urandom};
      #1;
      if (!rst) rd_left = 0;
      else begin
        if (dma_read_chnl_valid && dma_read_chnl_ready) begin rd_addr++; rd_left--; end
        if (dma_read_ctrl_valid && dma_read_ctrl_ready) begin
          rd_addr = int'(dma_read_ctrl_data_index);
          rd_left = int'(dma_read_ctrl_data_length);
        end
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents a handshake
  initial begin
    bit          prev_acc = 0, rd_stall = 0, wr_stall = 0;
    logic [63:0] rd_hold = 0, wr_hold = 0;
    int          wr_addr = 0;
    ctrl_t       c;
    beat_t       b;
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin prev_acc = 0; rd_stall = 0; wr_stall = 0; end
      else begin
        if (rd_stall) chk("rd_ctrl_stable", {dma_read_ctrl_valid, dma_read_ctrl_data_index, dma_read_ctrl_data_length}, {1'b1, rd_hold});
        if (wr_stall) chk("wr_ctrl_stable", {dma_write_ctrl_valid, dma_write_ctrl_data_index, dma_write_ctrl_data_length}, {1'b1, wr_hold});
        if (dma_read_ctrl_valid && dma_read_ctrl_ready) begin
          if (exp_rd.size() == 0) chk("rd_ctrl_unexpected", {dma_read_ctrl_data_index, dma_read_ctrl_data_length}, 96'hx);
          else begin
            c = exp_rd.pop_front();
            chk("rd_ctrl", {dma_read_ctrl_data_size, dma_read_ctrl_data_index, dma_read_ctrl_data_length}, {3'b011, c.idx, c.len});
          end
        end
        if (dma_write_ctrl_valid && dma_write_ctrl_ready) begin
          wr_addr = int'(dma_write_ctrl_data_index);
          if (exp_wr.size() == 0) chk("wr_ctrl_unexpected", {dma_write_ctrl_data_index, dma_write_ctrl_data_length}, 96'hx);
          else begin
            c = exp_wr.pop_front();
            chk("wr_ctrl", {dma_write_ctrl_data_size, dma_write_ctrl_data_index, dma_write_ctrl_data_length}, {3'b011, c.idx, c.len});
          end
        end
        if (dma_write_chnl_valid && dma_write_chnl_ready) begin
          if (exp_bt.size() == 0) chk("wr_beat_unexpected", dma_write_chnl_data, 96'hx);
          else begin
            b = exp_bt.pop_front();
            chk("wr_beat", {wr_addr, dma_write_chnl_data}, {b.addr, b.data});
          end
          wr_addr++;
        end
        if (acc_done) begin
          chk("acc_pulse_width", prev_acc, 0);
          chk("debug_chunks", debug[15:0], exp_chunks);
          acc_cnt++;
          acc_cyc = cyc;
        end
        prev_acc = acc_done;
        rd_stall = dma_read_ctrl_valid && !dma_read_ctrl_ready;
        rd_hold  = {dma_read_ctrl_data_index, dma_read_ctrl_data_length};
        wr_stall = dma_write_ctrl_valid && !dma_write_ctrl_ready;
        wr_hold  = {dma_write_ctrl_data_index, dma_write_ctrl_data_length};
      end
    end
  end

  task automatic expect_job(input int len, input int mode, input int in1, input int in2, input int outb);
    for (int off = 0; off < len; off += 16) begin
      int c = len - off < 16 ? len - off : 16;
      exp_rd.push_back('{in1 + off, c});
      exp_rd.push_back('{in2 + off, c});
      exp_wr.push_back('{outb + off, c});
    end
    for (int k = 0; k < len; k++) exp_bt.push_back('{outb + k, ref_op(mode, mem[in1 + k], mem[in2 + k])});
    exp_chunks = (len + 15) / 16;
  endtask

  task automatic start_job(input int len, input int mode, input int in1, input int in2, input int outb, output int t0);
    @(negedge clk);
    conf_info_len = len; conf_info_mode = {$urandom, 2'(mode)} & 32'hFFFF_FFFF;
    conf_info_in1_base = in1; conf_info_in2_base = in2; conf_info_out_base = outb;
    conf_done = 1;
    t0 = cyc;
    @(negedge clk);
    conf_done = 0;
    conf_info_len = $urandom; conf_info_in1_base = $urandom; conf_info_in2_base = $urandom; conf_info_out_base = $urandom;
  endtask

  task automatic run_job(input int len, input int mode, input int in1, input int in2, input int outb,
                         input bit lat, input bit extra);
    int t0, start;
    expect_job(len, mode, in1, in2, outb);
    start = acc_cnt;
    start_job(len, mode, in1, in2, outb, t0);
    if (extra) begin
      repeat (3) @(negedge clk);
      conf_info_len = 5;
      conf_done = 1;
      @(negedge clk);
      conf_done = 0;
    end
    for (int i = 0; i < 4000 && acc_cnt == start; i++) @(negedge clk);
    repeat (4) @(negedge clk);
    chk("acc_done_count", acc_cnt - start, 1);
    chk("queues_drained", exp_rd.size() + exp_wr.size() + exp_bt.size(), 0);
    if (lat) chk("latency", acc_cyc - t0 + 1, len == 0 ? 2 : 1 + 3 * (1 + len) + 1);
    exp_rd.delete(); exp_wr.delete(); exp_bt.delete();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, start;
    for (int i = 0; i < 1024; i++) mem[i] = {$urandom, $urandom};
    repeat (3) @(negedge clk);
    #1;
    chk("rst_valids", {dma_read_ctrl_valid, dma_read_chnl_ready, dma_write_ctrl_valid, dma_write_chnl_valid, acc_done}, 0);
    chk("rst_rd_ctrl", {dma_read_ctrl_data_index, dma_read_ctrl_data_length}, 0);
    chk("rst_wr_ctrl", {dma_write_ctrl_data_index, dma_write_ctrl_data_length}, 0);
    chk("rst_wr_data_debug", {dma_write_chnl_data, debug}, 0);
    rst = 1;

    for (int k = 0; k < 4; k++) begin mem[10 + k] = 64'h00000001_00000002; mem[300 + k] = 64'h00000010_00000020; end
    run_job(4, 0, 10, 300, 600, 1, 0);
    mem[20] = {32'hFFFFFFFF, 32'h00000007}; mem[320] = {32'h00000002, 32'h80000000};
    run_job(1, 2, 20, 320, 620, 1, 0);
    mem[21] = {32'h00000000, 32'h00000005}; mem[321] = {32'h00000001, 32'h00000007};
    run_job(1, 1, 21, 321, 621, 1, 0);
    mem[22] = {32'h80000000, 32'hFFFFFFFF}; mem[322] = {32'h00000001, 32'h00000001};
    run_job(1, 3, 22, 322, 622, 1, 0);
    run_job(20, 0, 40, 340, 640, 0, 0);
    run_job(0, 0, 0, 256, 512, 1, 0);
    run_job(16, 3, 60, 360, 700, 1, 0);
    run_job(37, 2, 100, 400, 700, 0, 0);
    stall = 1;
    run_job(37, 2, 100, 400, 700, 0, 1);
    for (int j = 0; j < 8; j++) begin
      stall = ($urandom % 2) != 0;
      run_job($urandom_range(1, 40), $urandom_range(0, 3), $urandom_range(0, 200),
              256 + $urandom_range(0, 200), 512 + $urandom_range(0, 200), 0, 0);
    end

    stall = 0;
    expect_job(20, 1, 30, 330, 560);
    start = acc_cnt;
    start_job(20, 1, 30, 330, 560, t0);
    for (int i = 0; i < 200 && debug[31:28] != 4'd4; i++) @(negedge clk);
    chk("reached_rd_b_data", debug[31:28], 4'd4);
    @(negedge clk);
    rst = 0;
    #1;
    chk("mid_rst_valids", {dma_read_ctrl_valid, dma_read_chnl_ready, dma_write_ctrl_valid, dma_write_chnl_valid, acc_done}, 0);
    chk("mid_rst_ctrl", {dma_read_ctrl_data_index, dma_read_ctrl_data_length, dma_write_ctrl_data_index}, 0);
    chk("mid_rst_data_debug", {dma_write_chnl_data, debug}, 0);
    exp_rd.delete(); exp_wr.delete(); exp_bt.delete();
    repeat (3) @(negedge clk);
    rst = 1;
    repeat (5) @(negedge clk);
    chk("no_acc_after_rst", acc_cnt - start, 0);
    stall = 1;
    run_job(20, 1, 30, 330, 560, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
